// File: rtl/capture_ctrl.sv
// capture_ctrl: sequences decimated sample writes into the five-channel RAM
// queue of the logic analyzer. Tracks pre-trigger fill (armed), counts
// post-trigger samples up to the clamped trigger position and signals
// completion to the config block.
//
// Optional build macro CAPTURE_TRIG_ADDR_EN adds the trig_addr output, which
// records the queue address of the first post-trigger sample so the host can
// locate the trigger point inside the dump.
module capture_ctrl #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wrt_smpl,
    input  logic            run,
    input  logic            capture_done,
    input  logic            triggered,
    input  logic [LOG2-1:0] trig_pos,
    output logic            we,
    output logic [LOG2-1:0] waddr,
    output logic            armed,
    output logic            set_capture_done
`ifdef CAPTURE_TRIG_ADDR_EN
    ,
    output logic [LOG2-1:0] trig_addr
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // ENTRIES in the widened (no-overflow) width and the last valid address
    localparam logic [LOG2:0]   C_ENTRIES = (LOG2+1)'(ENTRIES);
    localparam logic [LOG2-1:0] C_LAST    = LOG2'(ENTRIES - 1);

    state_t          r_state;
    logic [LOG2-1:0] r_waddr;
    logic [LOG2:0]   r_smpl_cnt;   // saturates at ENTRIES, needs one extra bit
    logic [LOG2-1:0] r_trig_cnt;   // never exceeds tp <= ENTRIES-1
    logic            r_armed;
`ifdef CAPTURE_TRIG_ADDR_EN
    logic [LOG2-1:0] r_trig_addr;
`endif

    logic [LOG2-1:0] w_tp;
    logic [LOG2:0]   w_arm_sum;
    logic            w_in_run;
    logic            w_complete;
    logic            w_write;
    logic [LOG2-1:0] w_waddr_inc;

    // Clamp trigger position so the post-trigger count can always be reached
    always_comb begin
        if ({1'b0, trig_pos} >= C_ENTRIES) begin
            w_tp = C_LAST;
        end else begin
            w_tp = trig_pos;
        end
    end

    // Decode the RUN-state priorities: run drop, then completion, then write
    always_comb begin
        w_arm_sum   = r_smpl_cnt + {1'b0, w_tp};
        w_in_run    = (r_state == RUN) && run;
        w_complete  = w_in_run && triggered && (r_trig_cnt == w_tp);
        w_write     = w_in_run && !w_complete && wrt_smpl;
        w_waddr_inc = (r_waddr == C_LAST) ? '0 : r_waddr + 1'b1;
    end

    // Control state, address pointer, counters and armed flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_waddr    <= '0;
            r_smpl_cnt <= '0;
            r_trig_cnt <= '0;
            r_armed    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (run && !capture_done) begin
                        r_state    <= RUN;
                        r_waddr    <= '0;
                        r_smpl_cnt <= '0;
                        r_trig_cnt <= '0;
                        r_armed    <= 1'b0;
                    end
                end
                RUN: begin
                    if (!run) begin
                        r_state <= IDLE;
                        r_armed <= 1'b0;
                    end else if (w_complete) begin
                        r_state <= DONE;
                        r_armed <= 1'b0;
                    end else begin
                        // armed is sticky once enough pre-trigger history exists
                        if (w_arm_sum >= C_ENTRIES) begin
                            r_armed <= 1'b1;
                        end
                        if (wrt_smpl) begin
                            r_waddr <= w_waddr_inc;
                            if (r_smpl_cnt != C_ENTRIES) begin
                                r_smpl_cnt <= r_smpl_cnt + 1'b1;
                            end
                            if (triggered) begin
                                r_trig_cnt <= r_trig_cnt + 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    // Everything holds so the host dumps a stable buffer
                    if (!capture_done) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef CAPTURE_TRIG_ADDR_EN
    // Remember where the first post-trigger sample lands in the queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trig_addr <= '0;
        end else if (r_state == IDLE && run && !capture_done) begin
            r_trig_addr <= '0;
        end else if (w_in_run && triggered && (r_trig_cnt == '0)) begin
            // waddr only moves together with trig_cnt once triggered, so
            // re-latching while trig_cnt is still zero stores the same value
            r_trig_addr <= r_waddr;
        end
    end

    assign trig_addr = r_trig_addr;
`endif

    assign we               = w_write;
    assign set_capture_done = w_complete;
    assign waddr            = r_waddr;
    assign armed            = r_armed;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed testbench for capture_ctrl (ENTRIES=384, LOG2=9).
module tb_capture_ctrl;

    localparam int ENTRIES = 384;
    localparam int LOG2    = 9;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wrt_smpl = 1'b0;
    logic            run = 1'b0;
    logic            capture_done = 1'b0;
    logic            triggered = 1'b0;
    logic [LOG2-1:0] trig_pos = '0;
    logic            we;
    logic [LOG2-1:0] waddr;
    logic            armed;
    logic            set_capture_done;
`ifdef CAPTURE_TRIG_ADDR_EN
    logic [LOG2-1:0] trig_addr;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    // Observation counters, written only by the monitor
    int we_cnt = 0;
    int scd_cnt = 0;
    int post_addrs[$];

    capture_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wrt_smpl         (wrt_smpl),
        .run              (run),
        .capture_done     (capture_done),
        .triggered        (triggered),
        .trig_pos         (trig_pos),
        .we               (we),
        .waddr            (waddr),
        .armed            (armed),
        .set_capture_done (set_capture_done)
`ifdef CAPTURE_TRIG_ADDR_EN
        ,
        .trig_addr        (trig_addr)
`endif
    );

    always #5 clk = ~clk;

    // Count writes and completion pulses mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (we) begin
            we_cnt <= we_cnt + 1;
            if (triggered) post_addrs.push_back(int'(waddr));
        end
        if (set_capture_done) scd_cnt <= scd_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int n);
        for (int i = 0; i < n; i++) begin
            wrt_smpl = 1'b1;
            tick();
        end
        wrt_smpl = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wrt_smpl = 1'b0;
        run = 1'b0;
        capture_done = 1'b0;
        triggered = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic start_run(input int tp);
        trig_pos = LOG2'(tp);
        run = 1'b1;
        capture_done = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        int s0;
        do_reset();
        tests_run++;
        if (waddr !== 9'd0 || armed !== 1'b0 || we !== 1'b0 || set_capture_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: waddr=%0d armed=%b we=%b scd=%b required 0/0/0/0", waddr, armed, we, set_capture_done);
        end
        start_run(383);
        strobe(80);
        tests_run++;
        if (waddr !== 9'h50 || armed !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_prefill: waddr=%0d armed=%b required 80/1", waddr, armed);
        end
        s0 = scd_cnt;
        wrt_smpl = 1'b1;
        triggered = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (waddr !== 9'd0 || armed !== 1'b0 || we !== 1'b0 || set_capture_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: waddr=%0d armed=%b we=%b scd=%b required 0/0/0/0", waddr, armed, we, set_capture_done);
        end
        tick();
        tick();
        tests_run++;
        if (scd_cnt !== s0) begin
            tests_failed++;
            $display("FAIL reset_no_done: scd pulses=%0d required 0", scd_cnt - s0);
        end
        wrt_smpl = 1'b0;
        triggered = 1'b0;
        run = 1'b0;
        rst_n = 1'b1;
        tick();
        $display("[TB] test_reset done");
    endtask

    task automatic test_normal();
        int w0, s0;
        do_reset();
        start_run(1);
        w0 = we_cnt;
        s0 = scd_cnt;
        strobe(383);
        tests_run++;
        if (armed !== 1'b0) begin
            tests_failed++;
            $display("FAIL normal_not_armed_383: armed=%b required 0", armed);
        end
        strobe(1);
        tests_run++;
        if (armed !== 1'b1) begin
            tests_failed++;
            $display("FAIL normal_armed_384: armed=%b required 1", armed);
        end
        strobe(7);
        tests_run++;
        if (waddr !== 9'd7 || we_cnt - w0 !== 391) begin
            tests_failed++;
            $display("FAIL normal_pretrig: waddr=%0d writes=%0d required 7/391", waddr, we_cnt - w0);
        end
        triggered = 1'b1;
        strobe(1);
        // Completion cycle: this strobe must be dropped
        wrt_smpl = 1'b1;
        tick();
        capture_done = 1'b1;
        strobe(7);
        triggered = 1'b0;
        tests_run++;
        if (waddr !== 9'd8 || we_cnt - w0 !== 392 || scd_cnt - s0 !== 1 || armed !== 1'b0) begin
            tests_failed++;
            $display("FAIL normal_done: waddr=%0d writes=%0d scd=%0d armed=%b required 8/392/1/0", waddr, we_cnt - w0, scd_cnt - s0, armed);
        end
        tick();
        tick();
        tick();
        tests_run++;
        if (waddr !== 9'd8 || we_cnt - w0 !== 392) begin
            tests_failed++;
            $display("FAIL normal_done_hold: waddr=%0d writes=%0d required 8/392", waddr, we_cnt - w0);
        end
        capture_done = 1'b0;
        tick();
        tests_run++;
        if (waddr !== 9'd8) begin
            tests_failed++;
            $display("FAIL done_to_idle: waddr=%0d required 8", waddr);
        end
        tick();
        tests_run++;
        if (waddr !== 9'd0) begin
            tests_failed++;
            $display("FAIL idle_to_run: waddr=%0d required 0", waddr);
        end
        run = 1'b0;
        tick();
        $display("[TB] test_normal done");
    endtask

    task automatic test_wrap();
        int w0, s0, p0;
        do_reset();
        start_run(10);
        strobe(383);
        tests_run++;
        if (waddr !== 9'd383 || armed !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_pre: waddr=%0d armed=%b required 383/1", waddr, armed);
        end
        w0 = we_cnt;
        s0 = scd_cnt;
        p0 = post_addrs.size();
        triggered = 1'b1;
        strobe(10);
        tests_run++;
        if (waddr !== 9'd9 || scd_cnt - s0 !== 0) begin
            tests_failed++;
            $display("FAIL wrap_post: waddr=%0d scd=%0d required 9/0", waddr, scd_cnt - s0);
        end
        wrt_smpl = 1'b1;
        tick();
        capture_done = 1'b1;
        wrt_smpl = 1'b0;
        tests_run++;
        if (scd_cnt - s0 !== 1 || we_cnt - w0 !== 10 || post_addrs.size() - p0 !== 10) begin
            tests_failed++;
            $display("FAIL wrap_done: scd=%0d writes=%0d recorded=%0d required 1/10/10", scd_cnt - s0, we_cnt - w0, post_addrs.size() - p0);
        end else begin
            for (int i = 0; i < 10; i++) begin
                tests_run++;
                if (post_addrs[p0 + i] !== ((i == 0) ? 383 : i - 1)) begin
                    tests_failed++;
                    $display("FAIL wrap_addr[%0d]: got %0d required %0d", i, post_addrs[p0 + i], (i == 0) ? 383 : i - 1);
                end
            end
        end
        // run is ignored while DONE
        run = 1'b0;
        triggered = 1'b0;
        strobe(3);
        tests_run++;
        if (waddr !== 9'd9 || we_cnt - w0 !== 10) begin
            tests_failed++;
            $display("FAIL wrap_hold: waddr=%0d writes=%0d required 9/10", waddr, we_cnt - w0);
        end
        capture_done = 1'b0;
        tick();
        tick();
        $display("[TB] test_wrap done");
    endtask

    task automatic test_abort();
        int w0, s0;
        do_reset();
        start_run(5);
        strobe(400);
        tests_run++;
        if (armed !== 1'b1 || waddr !== 9'd16) begin
            tests_failed++;
            $display("FAIL abort_pre: armed=%b waddr=%0d required 1/16", armed, waddr);
        end
        w0 = we_cnt;
        s0 = scd_cnt;
        run = 1'b0;
        tick();
        tests_run++;
        if (armed !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_armed: armed=%b required 0", armed);
        end
        strobe(4);
        tests_run++;
        if (we_cnt - w0 !== 0 || scd_cnt - s0 !== 0 || waddr !== 9'd16) begin
            tests_failed++;
            $display("FAIL abort_idle: writes=%0d scd=%0d waddr=%0d required 0/0/16", we_cnt - w0, scd_cnt - s0, waddr);
        end
        run = 1'b1;
        tick();
        tests_run++;
        if (waddr !== 9'd0 || armed !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_restart: waddr=%0d armed=%b required 0/0", waddr, armed);
        end
        run = 1'b0;
        tick();
        $display("[TB] test_abort done");
    endtask

    task automatic test_tp_zero();
        int w0, s0;
        do_reset();
        start_run(0);
        strobe(5);
        w0 = we_cnt;
        s0 = scd_cnt;
        triggered = 1'b1;
        wrt_smpl = 1'b1;
        @(negedge clk);
        tests_run++;
        if (we !== 1'b0 || set_capture_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL tp0_same_cycle: we=%b scd=%b required 0/1", we, set_capture_done);
        end
        tick();
        capture_done = 1'b1;
        wrt_smpl = 1'b0;
        triggered = 1'b0;
        tests_run++;
        if (waddr !== 9'd5 || we_cnt - w0 !== 0 || scd_cnt - s0 !== 1) begin
            tests_failed++;
            $display("FAIL tp0_done: waddr=%0d writes=%0d scd=%0d required 5/0/1", waddr, we_cnt - w0, scd_cnt - s0);
        end
        capture_done = 1'b0;
        tick();
        $display("[TB] test_tp_zero done");
    endtask

    task automatic test_tp_clamp();
        int s0, p0;
        do_reset();
        start_run(500);
        strobe(1);
        tests_run++;
        if (armed !== 1'b0) begin
            tests_failed++;
            $display("FAIL clamp_armed_early: armed=%b required 0", armed);
        end
        tick();
        tests_run++;
        if (armed !== 1'b1) begin
            tests_failed++;
            $display("FAIL clamp_armed: armed=%b required 1", armed);
        end
        s0 = scd_cnt;
        p0 = post_addrs.size();
        triggered = 1'b1;
        strobe(383);
        tests_run++;
        if (scd_cnt - s0 !== 0 || waddr !== 9'd0) begin
            tests_failed++;
            $display("FAIL clamp_post: scd=%0d waddr=%0d required 0/0", scd_cnt - s0, waddr);
        end
        tick();
        capture_done = 1'b1;
        triggered = 1'b0;
        tests_run++;
        if (scd_cnt - s0 !== 1 || post_addrs.size() - p0 !== 383) begin
            tests_failed++;
            $display("FAIL clamp_done: scd=%0d post_writes=%0d required 1/383", scd_cnt - s0, post_addrs.size() - p0);
        end
        capture_done = 1'b0;
        run = 1'b0;
        tick();
        $display("[TB] test_tp_clamp done");
    endtask

`ifdef CAPTURE_TRIG_ADDR_EN
    task automatic test_trig_addr();
        do_reset();
        start_run(5);
        strobe(300);
        triggered = 1'b1;
        strobe(5);
        tick();
        capture_done = 1'b1;
        triggered = 1'b0;
        tick();
        tick();
        tests_run++;
        if (trig_addr !== 9'h12C) begin
            tests_failed++;
            $display("FAIL trig_addr_done: got 0x%0h required 0x12c", trig_addr);
        end
        do_reset();
        tests_run++;
        if (trig_addr !== 9'd0) begin
            tests_failed++;
            $display("FAIL trig_addr_reset: got 0x%0h required 0x0", trig_addr);
        end
        $display("[TB] test_trig_addr done");
    endtask
`endif

    initial begin
        test_reset();
        test_normal();
        test_wrap();
        test_abort();
        test_tp_zero();
        test_tp_clamp();
`ifdef CAPTURE_TRIG_ADDR_EN
        test_trig_addr();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
